// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block and its generator counterpart.
package pwm_capture_pkg;

  localparam int PWM_W       = 21;
  localparam int PWM_TIMEOUT = 4000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_cap_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result bundle: period/high-time readings plus valid/lost/level status.
interface pwm_capture_if
  import pwm_capture_pkg::*;
#(
  parameter int W = PWM_W
);

  logic [W-1:0] period_out;
  logic [W-1:0] uptime_out;
  logic         valid;
  logic         lost;
  logic         level;

  modport master (
    output period_out,
    output uptime_out,
    output valid,
    output lost,
    output level
  );

  modport slave (
    input period_out,
    input uptime_out,
    input valid,
    input lost,
    input level
  );

endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus one delay flop for edge detection.
module pwm_capture_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [1:0] r_fill;
  logic       w_armed;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  // Edges count only once s3 holds a real sample, so a level already present
  // at reset release is not mistaken for an edge.
  assign w_armed = (r_fill == 2'd3);
  assign o_level = r_s2;
  assign o_rise  = w_armed & r_s2 & ~r_s3;
  assign o_fall  = w_armed & ~r_s2 & r_s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM period/high-time meter; readings use the generator encoding (period = rise spacing - 1).
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int W       = PWM_W,
  parameter int TIMEOUT = PWM_TIMEOUT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_sig,
  pwm_capture_if.master o_cap
);

  localparam logic [W-1:0] TO_CNT = W'(TIMEOUT);

  logic           w_s2;
  logic           w_rise;
  logic           w_fall;
  logic           w_timeout;

  pwm_cap_state_t r_state,  w_state_nxt;
  logic [W-1:0]   r_cnt,    w_cnt_nxt;
  logic [W-1:0]   r_up_tmp, w_up_tmp_nxt;
  logic [W-1:0]   r_period, w_period_nxt;
  logic [W-1:0]   r_uptime, w_uptime_nxt;
  logic           r_valid,  w_valid_nxt;
  logic           r_lost,   w_lost_nxt;
  logic           r_level,  w_level_nxt;

  pwm_capture_sync_edge u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_sig),
    .o_level (w_s2),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_timeout = (r_cnt == TO_CNT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_up_tmp <= '0;
      r_period <= '0;
      r_uptime <= '0;
      r_valid  <= 1'b0;
      r_lost   <= 1'b1;
      r_level  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_up_tmp <= w_up_tmp_nxt;
      r_period <= w_period_nxt;
      r_uptime <= w_uptime_nxt;
      r_valid  <= w_valid_nxt;
      r_lost   <= w_lost_nxt;
      r_level  <= w_level_nxt;
    end
  end

  // IDLE: waiting for a reference rise | HIGH: timing high phase | LOW: timing low phase
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = w_timeout ? r_cnt : r_cnt + W'(1);
    w_up_tmp_nxt = r_up_tmp;
    w_period_nxt = r_period;
    w_uptime_nxt = r_uptime;
    w_valid_nxt  = 1'b0;
    w_lost_nxt   = r_lost;
    w_level_nxt  = r_level;

    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
        end
      end
      HIGH, LOW: begin
        // Reaching the limit wins over a coincident edge: that cycle is too long to report.
        if (w_timeout) begin
          w_state_nxt  = IDLE;
          w_lost_nxt   = 1'b1;
          w_level_nxt  = w_s2;
          w_period_nxt = '0;
          w_uptime_nxt = '0;
        end else if (r_state == HIGH && w_fall) begin
          w_up_tmp_nxt = r_cnt + W'(1);
          w_state_nxt  = LOW;
        end else if (r_state == LOW && w_rise) begin
          w_period_nxt = r_cnt;
          w_uptime_nxt = r_up_tmp;
          w_valid_nxt  = 1'b1;
          w_lost_nxt   = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = HIGH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_cap.period_out = r_period;
  assign o_cap.uptime_out = r_uptime;
  assign o_cap.valid      = r_valid;
  assign o_cap.lost       = r_lost;
  assign o_cap.level      = r_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench: a behavioural PWM generator drives the capture block; readings checked against hand values.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int TO = 4000;

  logic clk = 1'b0;
  logic rst;
  logic sig;

  always #5 clk = ~clk;

  pwm_capture_if #(.W(PWM_W)) cap_if ();

  pwm_capture #(.W(PWM_W), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_sig (sig),
    .o_cap (cap_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // generator: period P means P+1 cycles per frame, high for the first U cycles
  int cyc = 0;
  bit gen_on = 1'b0;
  bit jitter = 1'b0;
  int gen_p = 1999, gen_u = 1500;
  int cur_p = 0, cur_u = 0, c = 0;
  bit lvl = 1'b0, lvl_q = 1'b0;
  int last_rise_cyc = 0, n_rise = 0;
  int dly = 2;

  initial begin
    sig = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (gen_on) begin
        if (c >= cur_p) begin
          c = 0; cur_p = gen_p; cur_u = gen_u;
        end else begin
          c++;
        end
        lvl = (c < cur_u);
      end else begin
        lvl = 1'b0;
      end
      if (lvl && !lvl_q) begin
        last_rise_cyc = cyc;
        n_rise++;
      end
      if (lvl != lvl_q) begin
        if (jitter) begin
          dly = $urandom_range(5, 14);
          if (dly >= 10) dly++;
        end else begin
          dly = 2;
        end
        fork
          begin
            automatic bit v  = lvl;
            automatic int dd = dly;
            #(dd) sig = v;
          end
        join_none
      end
      lvl_q = lvl;
    end
  end

  int n_valid = 0, v_cyc = 0, n_dbl = 0;
  longint v_p = 0, v_u = 0;
  bit valid_q = 1'b0;

  always @(negedge clk) begin
    if (cap_if.valid) begin
      n_valid++;
      v_cyc = cyc;
      v_p   = cap_if.period_out;
      v_u   = cap_if.uptime_out;
      if (valid_q) n_dbl++;
    end
    valid_q = cap_if.valid;
  end

  task automatic wait_valids(input int k, input int budget, input string tag);
    int n0 = n_valid;
    int t  = 0;
    while (n_valid < n0 + k && t < budget) begin
      @(negedge clk); #1; t++;
    end
    if (n_valid < n0 + k) chk_eq({tag, "_valid_timeout"}, n_valid - n0, k);
  endtask

  task automatic wait_lost(input bit want_level, input int budget, input string tag);
    int t = 0;
    while (!(cap_if.lost && cap_if.level == want_level) && t < budget) begin
      @(negedge clk); #1; t++;
    end
    if (!(cap_if.lost && cap_if.level == want_level)) chk_eq({tag, "_lost_timeout"}, cap_if.lost, 1);
  endtask

  function automatic bit near(input longint a, input longint b);
    return (a >= b - 1) && (a <= b + 1);
  endfunction

  initial begin
    int prev, nv, r0, t, bad;

    #900000;
    $display("FAIL watchdog: simulation ran out of time");
    $fatal(1);
  end

  initial begin
    int prev, nv, r0, t, bad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_period", cap_if.period_out, 0);
    chk_eq("rst_uptime", cap_if.uptime_out, 0);
    chk_eq("rst_valid",  cap_if.valid, 0);
    chk_eq("rst_lost",   cap_if.lost, 1);
    chk_eq("rst_level",  cap_if.level, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    gen_on = 1'b1;

    // 1999/1500 loopback
    wait_valids(1, 2200, "t1a");
    chk_eq("t1_period", v_p, 1999);
    chk_eq("t1_uptime", v_u, 1500);
    chk_eq("t1_lost",   cap_if.lost, 0);
    @(negedge clk); #1;
    chk_eq("t1_valid_width", cap_if.valid, 0);
    prev = v_cyc;
    wait_valids(1, 2200, "t1b");
    chk_eq("t1_spacing", v_cyc - prev, 2000);
    chk_eq("t1_period2", v_p, 1999);

    // short frames 9/1 then 9/9
    gen_p = 9; gen_u = 1;
    wait_valids(3, 2200, "t2a");
    chk_eq("t2_period_u1", v_p, 9);
    chk_eq("t2_uptime_u1", v_u, 1);
    prev = v_cyc;
    wait_valids(1, 50, "t2b");
    chk_eq("t2_spacing_u1", v_cyc - prev, 10);
    gen_u = 9;
    wait_valids(3, 100, "t2c");
    chk_eq("t2_period_u9", v_p, 9);
    chk_eq("t2_uptime_u9", v_u, 9);
    prev = v_cyc;
    wait_valids(1, 50, "t2d");
    chk_eq("t2_spacing_u9", v_cyc - prev, 10);

    // stuck low: lost lands TIMEOUT+1 cycles after the internal rise pulse
    gen_u = 0;
    wait_lost(1'b0, 6000, "t3");
    chk_eq("t3_lost_latency", cyc - last_rise_cyc, TO + 4);
    chk_eq("t3_level",  cap_if.level, 0);
    chk_eq("t3_period", cap_if.period_out, 0);
    chk_eq("t3_uptime", cap_if.uptime_out, 0);
    chk_eq("t3_no_late_valid", (v_cyc <= last_rise_cyc + 5), 1);

    // stuck high, then recover
    gen_p = 1999; gen_u = 2000;
    wait_lost(1'b1, 9000, "t4");
    chk_eq("t4_lost",   cap_if.lost, 1);
    chk_eq("t4_level",  cap_if.level, 1);
    chk_eq("t4_period", cap_if.period_out, 0);
    gen_u = 500;
    wait_valids(1, 6500, "t4r");
    chk_eq("t4_period_rec", v_p, 1999);
    chk_eq("t4_uptime_rec", v_u, 500);
    chk_eq("t4_lost_rec",   cap_if.lost, 0);

    // one-cycle reset in the middle of a high phase
    r0 = n_rise; t = 0;
    while (n_rise == r0 && t < 3000) begin
      @(negedge clk); t++;
    end
    repeat (100) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); #1;
    chk_eq("t5_period", cap_if.period_out, 0);
    chk_eq("t5_uptime", cap_if.uptime_out, 0);
    chk_eq("t5_lost",   cap_if.lost, 1);
    chk_eq("t5_valid",  cap_if.valid, 0);
    r0 = n_rise;
    wait_valids(1, 4500, "t5");
    chk_eq("t5_rises_before_valid", n_rise - r0, 2);
    chk_eq("t5_period_after", v_p, 1999);
    chk_eq("t5_uptime_after", v_u, 500);

    // jittered edges, readings within one cycle of nominal
    gen_p = 49; gen_u = 20; jitter = 1'b1;
    wait_valids(3, 2200, "t6a");
    for (int i = 0; i < 12; i++) begin
      wait_valids(1, 100, "t6b");
      chk_eq("t6_period_tol", near(v_p, 49), 1);
      chk_eq("t6_uptime_tol", near(v_u, 20), 1);
    end
    t = 0;
    while (c != 30 && t < 200) begin
      @(negedge clk); t++;
    end
    @(posedge clk); #3 sig = 1'b1; #3 sig = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      wait_valids(1, 100, "t6g");
      if (!near(v_p, 49) || !near(v_u, 20)) bad++;
    end
    chk_eq("t6_glitch_bad_le1", (bad <= 1), 1);
    jitter = 1'b0;

    // timeout boundary: TIMEOUT-1 still measures, TIMEOUT is a loss
    gen_p = TO - 1; gen_u = 100;
    wait_valids(3, 13000, "t7a");
    chk_eq("t7_period_max", v_p, TO - 1);
    chk_eq("t7_uptime_max", v_u, 100);
    gen_p = TO;
    nv = n_valid;
    wait_lost(1'b0, 13000, "t7b");
    chk_eq("t7_lost_at_to", cap_if.lost, 1);
    chk_eq("t7_at_most_one_valid", (n_valid - nv <= 1), 1);

    chk_eq("valid_single_cycle", n_dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
